// File: rtl/ex_mdu.sv
// Execute stage: single-cycle logic/shift/add/compare plus HI/LO and an iterative restoring divider.
// Define EX_DIV_EN to build the divider; without it DIV/DIVU act as NOP and stall_o is tied low.
module ex_mdu #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              flush_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_MFHI = 4'd14;
  localparam logic [3:0] OP_MFLO = 4'd15;

  logic [DATA_W-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]        alu_res;
  logic                     stall_req;
  logic                     is_div;
  logic [SHAMT_W-1:0]       shamt;
  logic signed [DATA_W-1:0] a_s, b_s;

  assign shamt  = reg1_i[SHAMT_W-1:0];
  assign a_s    = reg1_i;
  assign b_s    = reg2_i;
  assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);

  always_comb begin
    alu_res = '0;
    case (op_i)
      OP_AND:  alu_res = reg1_i & reg2_i;
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_NOR:  alu_res = ~(reg1_i | reg2_i);
      OP_SLL:  alu_res = reg2_i << shamt;
      OP_SRL:  alu_res = reg2_i >> shamt;
      OP_SRA:  alu_res = b_s >>> shamt;
      OP_ADD:  alu_res = reg1_i + reg2_i;
      OP_SUB:  alu_res = reg1_i - reg2_i;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Outputs are combinational, so reset has to mask them directly
  assign wd_o    = rst ? wd_i : 5'd0;
  assign wreg_o  = rst && wreg_i && (op_i != OP_NOP) && !is_div;
  assign wdata_o = rst ? alu_res : '0;
  assign stall_o = rst && stall_req;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              negq_q, negq_d, negr_q, negr_d;
  logic              div_signed, div_zero, div_start;
  logic [DATA_W:0]   rem_sh, diff;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  assign div_signed = (op_i == OP_DIV);
  assign div_zero   = (reg2_i == '0);
  assign div_start  = is_div && !div_zero && !flush_i;
  // Partial remainder stays below the divisor, so bit DATA_W of diff is a clean borrow flag
  assign rem_sh     = {rem_q, quo_q[DATA_W-1]};
  assign diff       = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (div_start) state_d = S_BUSY;
        S_BUSY:  if (cnt_q == DATA_W'(DATA_W-1)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      S_IDLE:  stall_req = div_start;
      S_BUSY:  stall_req = !flush_i;
      default: stall_req = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          quo_d  = mag(reg1_i, div_signed);
          dvs_d  = mag(reg2_i, div_signed);
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = div_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
          negr_d = div_signed && reg1_i[DATA_W-1];
        end else if (is_div && div_zero && !flush_i) begin
          lo_d = '1;
          hi_d = reg1_i;
        end
      end
      S_BUSY: begin
        rem_d = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
        cnt_d = cnt_q + DATA_W'(1);
      end
      S_DONE: begin
        if (!flush_i) begin
          lo_d = cneg(quo_q, negq_q);
          hi_d = cneg(rem_q, negr_q);
        end
      end
      default: ;
    endcase
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign stall_req    = 1'b0;
  assign hi_d         = hi_q;
  assign lo_d         = lo_q;
`endif

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: vector table and random ALU ops against a reference model, plus divider sequences.
module tb_ex_mdu;
  localparam int W = 32;
  localparam logic [3:0] OP_NOP = 4'd0, OP_SRA = 4'd7, OP_DIV = 4'd12, OP_DIVU = 4'd13;
  localparam logic [3:0] OP_MFHI = 4'd14, OP_MFLO = 4'd15;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   op_i;
  logic [W-1:0] reg1_i, reg2_i;
  logic [4:0]   wd_i;
  logic         wreg_i, flush_i;
  logic [4:0]   wd_o;
  logic         wreg_o, stall_o;
  logic [W-1:0] wdata_o, hi_o, lo_o;

  ex_mdu #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wreg;
    logic [31:0] exp_d;
    logic        exp_w;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference ALU from plain 64-bit arithmetic
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b,
                                            input logic [31:0] hi, lo);
    logic [63:0] ua, ub, t;
    longint sa, sb, p, q;
    int sh;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(a % 32);
    t  = 64'd0;
    case (op)
      4'd1:  t = ua & ub;
      4'd2:  t = ua | ub;
      4'd3:  t = ua ^ ub;
      4'd4:  t = ~(ua | ub);
      4'd5:  t = ub * (64'd1 << sh);
      4'd6:  t = ub / (64'd1 << sh);
      4'd7: begin
        p = longint'(64'd1 << sh);
        if (sb >= 0) q = sb / p;
        else         q = -((-sb + p - 1) / p);
        t = 64'(q);
      end
      4'd8:  t = ua + ub;
      4'd9:  t = ua - ub;
      4'd10: t = (sa < sb) ? 64'd1 : 64'd0;
      4'd11: t = (ua < ub) ? 64'd1 : 64'd0;
      4'd14: t = {32'd0, hi};
      4'd15: t = {32'd0, lo};
      default: t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  task automatic div_model(input logic [3:0] op, input logic [31:0] a, b,
                           output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else if (op == OP_DIVU) begin
      l = a / b;
      h = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      l  = q[31:0];
      h  = r[31:0];
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] wd,
                       input logic wr, input logic fl);
    @(posedge clk);
    #1;
    op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; flush_i = fl;
  endtask

  // Presents a division and counts stalled cycles; returns sampled in the DONE cycle
  task automatic div_run(input logic [3:0] op, input logic [31:0] a, b, output int nst,
                         output logic [31:0] h0, output logic [31:0] l0);
    drive(op, a, b, 5'd3, 1'b1, 1'b0);
    nst = 0;
    @(negedge clk);
    h0 = hi_o;
    l0 = lo_o;
    while (stall_o && nst < 200) begin
      nst++;
      @(negedge clk);
    end
  endtask

  task automatic do_div(input string nm, input logic [3:0] op, input logic [31:0] a, b);
    int nst;
    logic [31:0] h0, l0, eh, el;
    div_run(op, a, b, nst, h0, l0);
    chk({nm, " stall_cycles"}, 32'(nst), 32'd33);
    chk({nm, " hi_start"}, h0, exp_hi);
    chk({nm, " lo_start"}, l0, exp_lo);
    chk({nm, " done_wreg"}, 32'(wreg_o), 32'd0);
    chk({nm, " done_hi"}, hi_o, exp_hi);
    div_model(op, a, b, eh, el);
    exp_hi = eh;
    exp_lo = el;
    drive(OP_MFLO, a, b, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk({nm, " mflo"}, wdata_o, el);
    chk({nm, " hi"}, hi_o, eh);
    chk({nm, " lo"}, lo_o, el);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    logic [31:0] a, b, ed;
    int k;

    vecs[0]  = '{OP_SRA, 32'd4,          32'h8000_0000, 1'b1, 32'hF800_0000, 1'b1};
    vecs[1]  = '{4'd11,  32'd1,          32'hFFFF_FFFF, 1'b1, 32'd1,         1'b1};
    vecs[2]  = '{4'd10,  32'd5,          32'd5,         1'b1, 32'd0,         1'b1};
    vecs[3]  = '{4'd10,  32'hFFFF_FFFF,  32'd1,         1'b1, 32'd1,         1'b1};
    vecs[4]  = '{4'd11,  32'hFFFF_FFFF,  32'd1,         1'b1, 32'd0,         1'b1};
    vecs[5]  = '{4'd8,   32'hFFFF_FFFF,  32'd2,         1'b1, 32'd1,         1'b1};
    vecs[6]  = '{4'd9,   32'd0,          32'd1,         1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{4'd1,   32'hF0F0_F0F0,  32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b1};
    vecs[8]  = '{4'd2,   32'h0F0F_0000,  32'h0000_00F0, 1'b1, 32'h0F0F_00F0, 1'b1};
    vecs[9]  = '{4'd3,   32'hAAAA_5555,  32'hFFFF_0000, 1'b1, 32'h5555_5555, 1'b1};
    vecs[10] = '{4'd4,   32'd0,          32'd0,         1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{4'd5,   32'h21,         32'd1,         1'b1, 32'd2,         1'b1};
    vecs[12] = '{4'd6,   32'h3F,         32'h8000_0000, 1'b1, 32'd1,         1'b1};
    vecs[13] = '{OP_SRA, 32'd31,         32'h7FFF_FFFF, 1'b1, 32'd0,         1'b1};
    vecs[14] = '{OP_NOP, 32'd5,          32'd6,         1'b1, 32'd0,         1'b0};
    vecs[15] = '{4'd8,   32'd3,          32'd4,         1'b0, 32'd7,         1'b0};
    vecs[16] = '{OP_MFHI, 32'd9,         32'd9,         1'b1, 32'd0,         1'b1};
    vecs[17] = '{OP_SRA, 32'd0,          32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};

    rst = 1'b0;
    op_i = 4'd8; reg1_i = 32'd1; reg2_i = 32'd2; wd_i = 5'd5; wreg_i = 1'b1; flush_i = 1'b0;
    #3;
    chk("reset wdata", wdata_o, 32'd0);
    chk("reset wd", 32'(wd_o), 32'd0);
    chk("reset wreg", 32'(wreg_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].wreg, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp_d);
      chk($sformatf("vec%0d wreg", i), 32'(wreg_o), 32'(vecs[i].exp_w));
      chk($sformatf("vec%0d wd", i), 32'(wd_o), 32'(i));
      chk($sformatf("vec%0d stall", i), 32'(stall_o), 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      k  = int'($urandom_range(0, 12));
      op = (k < 11) ? 4'(k + 1) : ((k == 11) ? OP_MFHI : OP_MFLO);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      ed = alu_model(op, a, b, exp_hi, exp_lo);
      drive(op, a, b, 5'(i), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("rnd%0d op%0d wdata", i, op), wdata_o, ed);
      chk($sformatf("rnd%0d wreg", i), 32'(wreg_o), 32'd1);
      chk($sformatf("rnd%0d hi", i), hi_o, exp_hi);
    end

`ifdef EX_DIV_EN
    begin
      int nst;
      logic [31:0] h0, l0;

      do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_m7_2 lo const", lo_o, 32'hFFFF_FFFD);
      chk("div_m7_2 hi const", hi_o, 32'hFFFF_FFFF);

      drive(OP_DIVU, 32'h1234, 32'd0, 5'd1, 1'b1, 1'b0);
      @(negedge clk);
      chk("dbz stall", 32'(stall_o), 32'd0);
      chk("dbz wreg", 32'(wreg_o), 32'd0);
      drive(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("dbz lo", lo_o, 32'hFFFF_FFFF);
      chk("dbz hi", hi_o, 32'h1234);
      exp_lo = 32'hFFFF_FFFF;
      exp_hi = 32'h1234;

      drive(OP_DIVU, 32'd100, 32'd7, 5'd1, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("flush pre c%0d stall", c), 32'(stall_o), 32'd1);
      end
      @(posedge clk);
      #1 flush_i = 1'b1;
      @(negedge clk);
      chk("flush stall drop", 32'(stall_o), 32'd0);
      drive(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush after stall", 32'(stall_o), 32'd0);
      chk("flush hi kept", hi_o, exp_hi);
      chk("flush lo kept", lo_o, exp_lo);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("flush hi later", hi_o, exp_hi);
      chk("flush lo later", lo_o, exp_lo);

      div_run(OP_DIVU, 32'd100, 32'd7, nst, h0, l0);
      chk("b2b first stalls", 32'(nst), 32'd33);
      chk("b2b done stall", 32'(stall_o), 32'd0);
      div_run(OP_DIVU, 32'd9, 32'd3, nst, h0, l0);
      chk("b2b first hi", h0, 32'd2);
      chk("b2b first lo", l0, 32'd14);
      chk("b2b second stalls", 32'(nst), 32'd33);
      drive(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b second hi", hi_o, 32'd0);
      chk("b2b second lo", lo_o, 32'd3);
      chk("b2b no restart", 32'(stall_o), 32'd0);
      exp_hi = 32'd0;
      exp_lo = 32'd3;

      do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9);
      do_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10);
      for (int i = 0; i < 4; i++) begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 28);
        if (b == 32'd0) b = 32'd1;
        do_div($sformatf("rdiv%0d", i), (i % 2 == 0) ? OP_DIV : OP_DIVU, a, b);
      end

      drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rstbusy stall", 32'(stall_o), 32'd0);
      chk("rstbusy hi", hi_o, 32'd0);
      chk("rstbusy lo", lo_o, 32'd0);
      chk("rstbusy wdata", wdata_o, 32'd0);
      op_i = OP_NOP;
      @(negedge clk);
      rst = 1'b1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      #1;
      chk("rstbusy idle stall", 32'(stall_o), 32'd0);
      do_div("post_rst", OP_DIVU, 32'd9, 32'd3);
    end
`else
    drive(OP_DIV, 32'd7, 32'd2, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("nodiv stall", 32'(stall_o), 32'd0);
    chk("nodiv wreg", 32'(wreg_o), 32'd0);
    chk("nodiv wdata", wdata_o, 32'd0);
    drive(OP_DIVU, 32'h1234, 32'd0, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("nodiv dbz stall", 32'(stall_o), 32'd0);
    drive(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("nodiv hi", hi_o, exp_hi);
    chk("nodiv lo", lo_o, exp_lo);
    drive(OP_MFLO, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("nodiv mflo", wdata_o, exp_lo);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute stage for the in-order MIPS-style pipeline, sitting between ID/EX and EX/MEM. It computes logic, shift, add/subtract and set-less-than results in one cycle. It also owns the HI/LO register pair and performs DIV/DIVU with an iterative restoring divider. While a division is in flight, a stall request freezes the upstream pipeline.

## Interface
- DATA_W, 32: datapath width in bits (power of two, 8..64)
- SHAMT_W, $clog2(DATA_W): width of the shift-amount field taken from reg1_i
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- op_i  in  4  operation: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 ADD, 9 SUB, 10 SLT, 11 SLTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO
- reg1_i  in  DATA_W  operand A (shift amount = reg1_i[SHAMT_W-1:0]; dividend)
- reg2_i  in  DATA_W  operand B (shifted value; divisor)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable from decode
- flush_i  in  1  cancel in-flight division
- wd_o  out  5  destination address (= wd_i)
- wreg_o  out  1  write enable (wreg_i, forced 0 for NOP/DIV/DIVU)
- wdata_o  out  DATA_W  result
- stall_o  out  1  stall request to pipeline control
- hi_o, lo_o  out  DATA_W  current HI/LO register contents

## Operation
- ADD/SUB wrap modulo 2^DATA_W; no overflow trap.
- SLT is signed and SLTU is unsigned; result is 1 or 0, zero-extended.
- SRA fills with reg2_i[DATA_W-1].
- Shift amount uses only the low SHAMT_W bits.
- MFHI/MFLO return the HI/LO registers; there is no bypass.
- NOP and unused paths drive wdata_o = 0.
- wdata_o, wd_o, wreg_o and stall_o are combinational from inputs and FSM state.
- Divider FSM states are IDLE, BUSY and DONE. A DATA_W-bit counter `cnt` runs in BUSY.
- IDLE, op_i∈{DIV,DIVU}, reg2_i≠0, flush_i=0:
  - latch |dividend| and |divisor| (raw values for DIVU) and the two sign bits
  - cnt←0, go to BUSY; stall_o=1
- IDLE, op_i∈{DIV,DIVU}, reg2_i=0: no stall; at the clock edge LO←all-ones, HI←reg1_i; stay IDLE.
- BUSY: one restoring step per cycle, MSB first; stall_o=1.
  - After DATA_W steps go to DONE.
- DONE: stall_o=0; at the clock edge HI/LO are written and the FSM goes to IDLE.
  - DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - MIN/−1 yields LO=MIN, HI=0 naturally.
- DONE does not restart even though op_i still shows DIV; the next division starts only from IDLE.
- flush_i=1 in any state: go to IDLE next edge, no HI/LO write, stall_o=0 that cycle.
- Operands are latched at start; reg1_i/reg2_i changes during BUSY are ignored.

## Timing
- Non-divide ops have 0-cycle combinational latency; HI/LO are untouched.
- DIV/DIVU with nonzero divisor, presented in cycle 0:
  - stall_o high in cycles 0..DATA_W (DATA_W+1 cycles)
  - cycle DATA_W+1 is DONE with stall_o low
  - HI/LO are valid from cycle DATA_W+2
- Upstream holds op_i/reg*_i stable while stall_o=1.
- Reset (rst=0, any time including mid-BUSY) drives, asynchronously:
  - FSM=IDLE, cnt=0, HI=LO=0
  - wd_o=0, wreg_o=0, wdata_o=0, stall_o=0

## Configuration
- EX_DIV_EN defined: the iterative divider is built as above.
- EX_DIV_EN undefined:
  - no divider logic or FSM is built
  - DIV/DIVU behave as NOP (HI/LO unchanged, wreg_o=0), and stall_o is tied 0

## Test plan
- Reset mid-BUSY: assert rst=0 during cycle 10 of a DIV -> stall_o=0, hi_o=lo_o=0 immediately; FSM in IDLE after release.
- Logic/shift: DATA_W=32, SRA reg2=0x80000000, reg1=4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same operands -> 0.
- DIV: −7 / 2 -> stall_o for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; MFLO in cycle 34 returns 0xFFFFFFFD.
- Divide by zero: DIVU 0x1234 / 0 -> no stall, next cycle LO=0xFFFFFFFF, HI=0x1234.
- Flush: DIVU 100/7, flush_i at cycle 5 -> stall_o drops that cycle; HI/LO keep their prior values.
- Back-to-back: DIVU 100/7 then DIVU 9/3 -> HI=2, LO=14, then HI=0, LO=3; no restart is triggered from DONE.
